// File: rtl/ysyx_22040365_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040365_ifu_if
//  Bundle of the instruction fetch unit's external handshakes:
//   - memory side : imem_req/imem_addr -> imem_gnt, then imem_rvalid/imem_rdata
//   - redirect    : redirect strobe and redirect_pc target from later stages
//   - decode side : inst_valid/inst/inst_pc -> inst_ready
//  modport master : the fetch unit's view
//  modport slave  : the environment's view (memory, redirect source, decode)
// ----------------------------------------------------------------------------
interface ysyx_22040365_ifu_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [63:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ysyx_22040365_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040365_ifu
//  Instruction fetch unit. Holds the PC, issues word fetches over a req/gnt +
//  rvalid memory interface, buffers returned words with their PCs in a small
//  queue and presents the queue head to decode over valid/ready. A redirect
//  retargets the PC, flushes the queue and marks every in-flight fetch as
//  stale so its return is discarded.
//
//  Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   bus (master)   memory, redirect and decode handshakes (ysyx_22040365_ifu_if)
//   perf_fetch_cnt words pushed into the queue       (YSYX_22040365_IFU_PERF_EN)
//   perf_stall_cnt cycles with inst_ready & ~inst_valid (YSYX_22040365_IFU_PERF_EN)
//
//  Optional feature macro: YSYX_22040365_IFU_PERF_EN
// ----------------------------------------------------------------------------
module ysyx_22040365_ifu #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_22040365_ifu_if.master   bus
`ifdef YSYX_22040365_IFU_PERF_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_stall_cnt
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    // Back-to-back redirects can stack stale fetches beyond QDEPTH, so the
    // drop counter gets headroom over the queue-sized counters.
    localparam int DW = CW + 2;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] qcount_q, qcount_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [PW-1:0] q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
    logic [PW-1:0] r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;

    logic [31:0]   q_inst_q [QDEPTH];   // instruction queue: word
    logic [63:0]   q_pc_q   [QDEPTH];   // instruction queue: its PC
    logic [63:0]   r_pc_q   [QDEPTH];   // PCs of live in-flight requests

    logic fire, pop, ret_drop, ret_push;

    // Credit rule: queued plus live in-flight words never exceed QDEPTH, so a
    // return always finds a free slot. Held low while reset is asserted.
    assign bus.imem_req  = rst_n & ~bus.redirect & ((qcount_q + outst_q) < QD);
    assign bus.imem_addr = pc_q;

    assign fire     = bus.imem_req & bus.imem_gnt;
    assign pop      = bus.inst_valid & bus.inst_ready;
    assign ret_drop = bus.imem_rvalid & (drop_q != '0);
    // Returns with no live request outstanding are protocol errors; ignore them.
    assign ret_push = bus.imem_rvalid & (drop_q == '0) & (outst_q != '0) & ~bus.redirect;

    // Outputs come only from registered storage; masking with inst_valid keeps
    // flushed entries from ever showing on inst/inst_pc.
    assign bus.inst_valid = (qcount_q != '0);
    assign bus.inst       = bus.inst_valid ? q_inst_q[q_rptr_q] : 32'd0;
    assign bus.inst_pc    = bus.inst_valid ? q_pc_q[q_rptr_q]   : 64'd0;

    // NOTE: every always_comb output is given its hold value first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d     = pc_q;
        qcount_d = qcount_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        q_wptr_d = q_wptr_q;
        q_rptr_d = q_rptr_q;
        r_wptr_d = r_wptr_q;
        r_rptr_d = r_rptr_q;

        if (bus.redirect) begin
            // Every live fetch turns stale; a return arriving now is itself
            // discarded and retires one of the stale-or-live slots.
            pc_d     = {bus.redirect_pc[63:2], 2'b00};
            qcount_d = '0;
            outst_d  = '0;
            q_wptr_d = '0;
            q_rptr_d = '0;
            r_wptr_d = '0;
            r_rptr_d = '0;
            drop_d   = drop_q + DW'(outst_q);
            if (bus.imem_rvalid && (drop_q != '0 || outst_q != '0))
                drop_d = drop_q + DW'(outst_q) - DW'(1);
        end else begin
            if (fire) begin
                pc_d     = pc_q + 64'd4;
                r_wptr_d = r_wptr_q + 1'b1;
            end
            if (ret_drop)
                drop_d = drop_q - DW'(1);
            if (ret_push) begin
                q_wptr_d = q_wptr_q + 1'b1;
                r_rptr_d = r_rptr_q + 1'b1;
            end
            if (pop)
                q_rptr_d = q_rptr_q + 1'b1;
            qcount_d = qcount_q + CW'(ret_push) - CW'(pop);
            outst_d  = outst_q + CW'(fire) - CW'(ret_push);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_RESET;
            qcount_q <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            q_wptr_q <= '0;
            q_rptr_q <= '0;
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            qcount_q <= qcount_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            q_wptr_q <= q_wptr_d;
            q_rptr_q <= q_rptr_d;
            r_wptr_q <= r_wptr_d;
            r_rptr_q <= r_rptr_d;
        end
    end

    // NOTE: the storage arrays carry no reset; occupancy counters decide
    // validity and the outputs are masked, so their contents are don't-care.
    always_ff @(posedge clk) begin
        if (fire)
            r_pc_q[r_wptr_q] <= pc_q;
        if (ret_push) begin
            q_inst_q[q_wptr_q] <= bus.imem_rdata;
            q_pc_q[q_wptr_q]   <= r_pc_q[r_rptr_q];
        end
    end

`ifdef YSYX_22040365_IFU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (ret_push)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (bus.inst_ready && !bus.inst_valid)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule
